clock_div: RTL and testbench

- Parameterised integer clock divider. Derives a slow, roughly 50 % duty-cycle clock from the 50 MHz system clock.
- Typical use: a DIV=5000 instance produces a 0.1 ms period tick base for servo PWM generation; a DIV=5_000_000 instance produces a 0.1 s base for speed sequencing.
- Also provides a one-cycle strobe aligned to each rising edge of the divided clock, for logic that stays in the clkin domain.

---
 rtl/clock_div_if.sv | 12 +
 rtl/clock_div.sv | 63 ++++++
 tb/tb_clock_div.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_div_if.sv
// Output bundle of the clock divider: the divided clock and its rising-edge
// strobe. The divider drives it through the master modport, and consumers
// read it through the slave modport.
`timescale 1ns/1ps

interface clock_div_if;
  logic clkout;
  logic tick;

  modport master (output clkout, output tick);
  modport slave  (input  clkout, input  tick);
endinterface : clock_div_if

// File: rtl/clock_div.sv
// Integer clock divider.
// clkout has a period of exactly DIV clkin cycles. It is high for ceil(DIV/2)
// cycles and then low for floor(DIV/2) cycles, so an odd DIV puts the extra
// cycle in the high phase. tick is a one-cycle strobe in the clkin domain. It
// is high in the cycle where clkout has just risen.
// Both outputs come straight from flops, so neither one can glitch.
`timescale 1ns/1ps

module clock_div #(
  parameter int DIV = 5000,
  parameter int CW  = $clog2(DIV)   // derived; do not override
) (
  input  logic             clkin,
  input  logic             reset,
  clock_div_if.master      div
);

  // A ratio below 2 cannot produce a clock with both phases.
  if (DIV < 2) begin : g_bad_div
    $error("clock_div: DIV must be >= 2, got %0d", DIV);
  end

  // Length of the high phase, which is ceil(DIV/2).
  localparam int HIGH = DIV - DIV / 2;

  // Compare constants sized to the counter. The wrap value is DIV-1, not
  // 2^CW-1, so a ratio that is not a power of two still wraps exactly.
  localparam logic [CW-1:0] LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] HIGH_C = CW'(HIGH);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          clkout_q;
  logic          tick_q;

  // Next count: advance, and wrap back to 0 after DIV-1.
  always_comb begin
    // NOTE: cnt_n gets a value on every path through this block, so no latch is inferred.
    cnt_n = (cnt == LAST) ? '0 : cnt + ONE;
  end

  // Counter and output flops. The outputs are decoded from the next count, so
  // each one changes on the same edge as the counter it describes.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      // Reset parks the counter at DIV-1. The first edge after release then
      // wraps it to 0, which raises clkout and tick on that edge.
      cnt      <= LAST;
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample the pre-edge values, which avoids update-order races.
      cnt      <= cnt_n;
      clkout_q <= (cnt_n < HIGH_C);
      tick_q   <= (cnt_n == '0);
    end
  end

  assign div.clkout = clkout_q;
  assign div.tick   = tick_q;

endmodule : clock_div

// File: tb/tb_clock_div.sv
// Bench for clock_div. Five instances (DIV = 2, 4, 5, 7, 5000) share one
// 50 MHz clkin and one reset. The expected value at the k-th edge after reset
// release comes from the period rule:
//   phase = (k-1) mod DIV, clkout = (phase < ceil(DIV/2)), tick = (phase == 0).
`timescale 1ns/1ps

module tb_clock_div;

  logic clkin = 1'b0;
  logic reset = 1'b1;

  int n_total = 0;
  int n_pass  = 0;

  always #10 clkin = ~clkin;   // 50 MHz

  clock_div_if if2 ();
  clock_div_if if4 ();
  clock_div_if if5 ();
  clock_div_if if7 ();
  clock_div_if if5000 ();

  clock_div #(.DIV(2))    dut2    (.clkin(clkin), .reset(reset), .div(if2));
  clock_div #(.DIV(4))    dut4    (.clkin(clkin), .reset(reset), .div(if4));
  clock_div #(.DIV(5))    dut5    (.clkin(clkin), .reset(reset), .div(if5));
  clock_div #(.DIV(7))    dut7    (.clkin(clkin), .reset(reset), .div(if7));
  clock_div #(.DIV(5000)) dut5000 (.clkin(clkin), .reset(reset), .div(if5000));

  // Reference model: value expected at the k-th edge after release (k >= 1).
  function automatic logic exp_clk(input int d, input int k);
    int ph;
    ph = (k - 1) % d;
    return logic'(ph < (d - d / 2));
  endfunction

  function automatic logic exp_tick(input int d, input int k);
    return logic'(((k - 1) % d) == 0);
  endfunction

  // Observation helpers: select an instance by its ratio.
  function automatic logic obs_clk(input int d);
    case (d)
      2:       return if2.clkout;
      4:       return if4.clkout;
      5:       return if5.clkout;
      7:       return if7.clkout;
      default: return if5000.clkout;
    endcase
  endfunction

  function automatic logic obs_tick(input int d);
    case (d)
      2:       return if2.tick;
      4:       return if4.tick;
      5:       return if5.tick;
      7:       return if7.tick;
      default: return if5000.tick;
    endcase
  endfunction

  // Assert reset between edges, hold it, and release it just after a falling
  // edge. The next rising edge is then edge 1.
  task automatic do_reset();
    @(negedge clkin);
    #3 reset = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clkin);
    reset = 1'b0;
  endtask

  // Reset state: all outputs are low and the counters are parked at DIV-1.
  task automatic test_reset();
    int divs[5] = '{2, 4, 5, 7, 5000};
    reset = 1'b1;
    repeat (2) @(posedge clkin);
    #1;
    foreach (divs[i]) begin
      n_total++;
      if (obs_clk(divs[i]) !== 1'b0 || obs_tick(divs[i]) !== 1'b0)
        $display("FAIL reset_state div=%0d: clkout=%b tick=%b, want 0 0",
                 divs[i], obs_clk(divs[i]), obs_tick(divs[i]));
      else n_pass++;
    end
    n_total++;
    if (dut7.cnt !== 3'd6) $display("FAIL reset_cnt7: got %0d want 6", dut7.cnt);
    else n_pass++;
    n_total++;
    if (dut4.cnt !== 2'd3) $display("FAIL reset_cnt4: got %0d want 3", dut4.cnt);
    else n_pass++;
  endtask

  // Run n edges and compare one instance against the model at every edge.
  task automatic test_pattern(input int d, input int n);
    logic c, t;
    do_reset();
    for (int k = 1; k <= n; k++) begin
      @(posedge clkin);
      #1;
      c = obs_clk(d);
      t = obs_tick(d);
      n_total++;
      if (c !== exp_clk(d, k) || t !== exp_tick(d, k))
        $display("FAIL pattern div=%0d edge=%0d: clkout=%b tick=%b, want %b %b",
                 d, k, c, t, exp_clk(d, k), exp_tick(d, k));
      else n_pass++;
      if (d == 2) begin
        n_total++;
        if (t !== c) $display("FAIL div2_tick_eq_clk edge=%0d: tick=%b clkout=%b", k, t, c);
        else n_pass++;
      end
    end
  endtask

  // Asynchronous reset while clkout is high: the outputs drop with no edge,
  // and the pattern restarts from edge 1 after release.
  task automatic test_async_reset();
    int kt;
    do_reset();
    kt = 1 + 4 * int'($urandom_range(0, 2)) + int'($urandom_range(0, 1));
    for (int k = 1; k <= kt; k++) begin
      @(posedge clkin);
      #1;
    end
    n_total++;
    if (if4.clkout !== exp_clk(4, kt))
      $display("FAIL async_pre edge=%0d: clkout=%b want %b", kt, if4.clkout, exp_clk(4, kt));
    else n_pass++;
    #($urandom_range(1, 15));
    reset = 1'b1;
    #1;
    n_total++;
    if (if4.clkout !== 1'b0 || if4.tick !== 1'b0)
      $display("FAIL async_drop: clkout=%b tick=%b, want 0 0", if4.clkout, if4.tick);
    else n_pass++;
    repeat ($urandom_range(1, 3)) @(negedge clkin);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clkin);
      #1;
      n_total++;
      if (if4.clkout !== exp_clk(4, k) || if4.tick !== exp_tick(4, k))
        $display("FAIL async_restart edge=%0d: clkout=%b tick=%b, want %b %b",
                 k, if4.clkout, if4.tick, exp_clk(4, k), exp_tick(4, k));
      else n_pass++;
    end
  endtask

  // DIV=5000 over three periods: spacing of the rising edges, high time, and
  // the number of ticks.
  task automatic test_div5000();
    int rises[$];
    int high1, ticks;
    logic prev, c;
    high1 = 0;
    ticks = 0;
    prev  = 1'b0;
    do_reset();
    for (int k = 1; k <= 15000; k++) begin
      @(posedge clkin);
      #1;
      c = if5000.clkout;
      if (c && !prev) rises.push_back(k);
      if (c && k <= 5000) high1++;
      if (if5000.tick) ticks++;
      prev = c;
    end
    n_total++;
    if (rises.size() !== 3) $display("FAIL d5000_rises: got %0d want 3", rises.size());
    else n_pass++;
    if (rises.size() >= 3) begin
      n_total++;
      if (rises[0] !== 1) $display("FAIL d5000_first: got %0d want 1", rises[0]);
      else n_pass++;
      for (int i = 1; i < 3; i++) begin
        n_total++;
        if (rises[i] - rises[i-1] !== 5000)
          $display("FAIL d5000_gap%0d: got %0d want 5000", i, rises[i] - rises[i-1]);
        else n_pass++;
      end
    end
    n_total++;
    if (high1 !== 2500) $display("FAIL d5000_high: got %0d want 2500", high1);
    else n_pass++;
    n_total++;
    if (ticks !== 3) $display("FAIL d5000_ticks: got %0d want 3", ticks);
    else n_pass++;
  endtask

  // DIV=7: the counter stays below 7, the high phase is 4 cycles per period,
  // and rising edges are exactly 7 cycles apart.
  task automatic test_div7();
    int n, highs, last_rise;
    logic prev;
    n = 21 + 7 * int'($urandom_range(0, 2));
    highs = 0;
    last_rise = 0;
    prev = 1'b0;
    do_reset();
    for (int k = 1; k <= n; k++) begin
      @(posedge clkin);
      #1;
      n_total++;
      if (dut7.cnt >= 3'd7) $display("FAIL d7_cnt edge=%0d: got %0d want <7", k, dut7.cnt);
      else n_pass++;
      n_total++;
      if (if7.clkout !== exp_clk(7, k) || if7.tick !== exp_tick(7, k))
        $display("FAIL d7_pattern edge=%0d: clkout=%b tick=%b, want %b %b",
                 k, if7.clkout, if7.tick, exp_clk(7, k), exp_tick(7, k));
      else n_pass++;
      if (if7.clkout && !prev) begin
        if (last_rise != 0) begin
          n_total++;
          if (k - last_rise !== 7) $display("FAIL d7_period: got %0d want 7", k - last_rise);
          else n_pass++;
        end
        last_rise = k;
      end
      if (if7.clkout) highs++;
      prev = if7.clkout;
    end
    n_total++;
    if (highs !== 4 * (n / 7)) $display("FAIL d7_high: got %0d want %0d", highs, 4 * (n / 7));
    else n_pass++;
  endtask

  // Back-to-back random runs: random reset timing and random run lengths,
  // with every small instance compared against the model at each edge.
  task automatic test_back_to_back();
    int divs[4] = '{2, 4, 5, 7};
    int n;
    repeat (6) begin
      do_reset();
      n = $urandom_range(1, 40);
      for (int k = 1; k <= n; k++) begin
        @(posedge clkin);
        #1;
        foreach (divs[i]) begin
          n_total++;
          if (obs_clk(divs[i]) !== exp_clk(divs[i], k) || obs_tick(divs[i]) !== exp_tick(divs[i], k))
            $display("FAIL random div=%0d edge=%0d: clkout=%b tick=%b, want %b %b",
                     divs[i], k, obs_clk(divs[i]), obs_tick(divs[i]),
                     exp_clk(divs[i], k), exp_tick(divs[i], k));
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern(4, 12);
    test_pattern(5, 15);
    test_pattern(2, 8);
    test_async_reset();
    test_div5000();
    test_div7();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so that the run always ends.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded 2 ms, want completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_clock_div
